// File: rtl/he_sequencer.sv
// he_sequencer: frame phase controller for histogram equalization.
// Sequences CLEAR -> ACCUM -> DRAIN -> CDF -> MAP -> DONE over a two-pass
// pixel stream. It owns the histogram RAM ports (1R1W, 1-cycle read) and the
// LUT build strobe. Optional bin saturation is enabled with `HE_CLIP_EN.
module he_sequencer #(
  parameter int IMAGE_WIDTH  = 660,
  parameter int IMAGE_HEIGHT = 440,
  parameter int CNT_W        = 19,
  parameter int CLIP_LIMIT   = 2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_pixel,
  output logic             in_ready,
  output logic [7:0]       hist_raddr,
  input  logic [CNT_W-1:0] hist_rdata,
  output logic             hist_we,
  output logic [7:0]       hist_waddr,
  output logic [CNT_W-1:0] hist_wdata,
  output logic             lut_we,
  output logic [7:0]       lut_waddr,
  output logic [CNT_W-1:0] lut_cdf,
  output logic [CNT_W-1:0] lut_cdf_min,
  output logic             map_valid,
  output logic [7:0]       map_pixel,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             done
);

  localparam int N = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CDF   = 3'd4;
  localparam logic [2:0] S_MAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Parameter sanity: the CDF must never wrap and the clip value must fit.
  if (2**CNT_W <= N) begin : g_bad_cnt_w
    $error("he_sequencer: CNT_W too small for IMAGE_WIDTH*IMAGE_HEIGHT");
  end
  if (CLIP_LIMIT < 1 || CLIP_LIMIT >= 2**CNT_W) begin : g_bad_clip
    $error("he_sequencer: CLIP_LIMIT out of range for CNT_W");
  end

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [8:0]       idx;        // clear bin index / CDF read index (0..256)
  logic             beat, last_beat;
  logic             pend_vld;   // histogram increment waiting for read data
  logic [7:0]       pend_pix;
  logic             fwd_hit;    // pending bin was being written when it was read
  logic [CNT_W-1:0] fwd_val;
  logic             pend_we;
  logic [CNT_W-1:0] cnt_base, cnt_inc;
  logic [CNT_W-1:0] cdf_acc, cdf_sum, cdf_min;

  assign in_ready  = (state == S_ACCUM) || (state == S_MAP);
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (beat_cnt == LAST_BEAT);
  assign pend_we   = pend_vld && ((state == S_ACCUM) || (state == S_DRAIN));

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: if (idx == 9'd255) state_nxt = S_ACCUM;
      S_ACCUM: if (last_beat) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_CDF;
      S_CDF:   if (idx == 9'd256) state_nxt = S_MAP;
      S_MAP:   if (last_beat) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Increment value: a bin written in the same cycle it was read returns stale
  // RAM data, so the in-flight write value is forwarded instead.
  always_comb begin
    cnt_base = fwd_hit ? fwd_val : hist_rdata;
`ifdef HE_CLIP_EN
    cnt_inc  = (cnt_base >= CNT_W'(CLIP_LIMIT)) ? CNT_W'(CLIP_LIMIT)
                                                 : cnt_base + CNT_W'(1);
`else
    cnt_inc  = cnt_base + CNT_W'(1);
`endif
  end

  // Histogram RAM port drive.
  always_comb begin
    hist_raddr = 8'd0;
    if (state == S_ACCUM)    hist_raddr = in_pixel;
    else if (state == S_CDF) hist_raddr = idx[7:0];
    hist_we    = (state == S_CLEAR) || pend_we;
    hist_waddr = 8'd0;
    if (state == S_CLEAR) hist_waddr = idx[7:0];
    else if (pend_we)     hist_waddr = pend_pix;
    hist_wdata = pend_we ? cnt_inc : '0;
  end

  // LUT build strobe: read data for bin idx-1 arrives on cycle idx.
  always_comb begin
    lut_we    = (state == S_CDF) && (idx != 9'd0);
    cdf_sum   = cdf_acc + hist_rdata;
    lut_waddr = lut_we ? (idx[7:0] - 8'd1) : 8'd0;
    lut_cdf   = lut_we ? cdf_sum : '0;
  end

  assign lut_cdf_min = cdf_min;
  assign map_valid   = (state == S_MAP) && in_valid;
  assign map_pixel   = map_valid ? in_pixel : 8'd0;
  assign phase       = state;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  // State, counters, increment pipeline and CDF accumulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      idx      <= '0;
      pend_vld <= 1'b0;
      pend_pix <= 8'd0;
      fwd_hit  <= 1'b0;
      fwd_val  <= '0;
      cdf_acc  <= '0;
      cdf_min  <= '0;
    end else begin
      state <= state_nxt;
      if (state != state_nxt)                      idx <= '0;
      else if (state == S_CLEAR || state == S_CDF) idx <= idx + 9'd1;
      if (state != state_nxt) beat_cnt <= '0;
      else if (beat)          beat_cnt <= beat_cnt + CNT_W'(1);
      pend_vld <= (state == S_ACCUM) && beat;
      pend_pix <= in_pixel;
      fwd_hit  <= (state == S_ACCUM) && beat && pend_vld && (in_pixel == pend_pix);
      fwd_val  <= hist_wdata;
      if (state == S_IDLE && start) begin
        cdf_acc <= '0;
        cdf_min <= '0;
      end else if (lut_we) begin
        cdf_acc <= cdf_sum;
        if (cdf_min == '0 && cdf_sum != '0) cdf_min <= cdf_sum;
      end
    end
  end

endmodule

// File: tb/tb_he_sequencer.sv
// tb_he_sequencer: directed bench for he_sequencer on a 4x4 frame (N=16,
// CNT_W=5). Provides a 1R1W histogram RAM model and captures LUT strobes.
module tb_he_sequencer;
  localparam int W = 4, H = 4, CW = 5, CL = 4, N = 16;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_pixel;
  logic          in_ready, hist_we, lut_we, map_valid, busy, done;
  logic [7:0]    hist_raddr, hist_waddr, lut_waddr, map_pixel;
  logic [CW-1:0] hist_rdata, hist_wdata, lut_cdf, lut_cdf_min;
  logic [2:0]    phase;

  he_sequencer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CNT_W(CW), .CLIP_LIMIT(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .hist_raddr(hist_raddr), .hist_rdata(hist_rdata),
    .hist_we(hist_we), .hist_waddr(hist_waddr), .hist_wdata(hist_wdata),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_cdf(lut_cdf), .lut_cdf_min(lut_cdf_min),
    .map_valid(map_valid), .map_pixel(map_pixel), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Histogram RAM: registered read returns old data on a same-cycle write.
  logic [CW-1:0] mem [256];
  always @(posedge clk) begin
    if (hist_we) mem[hist_waddr] <= hist_wdata;
    hist_rdata <= mem[hist_raddr];
  end

  // Monitors: cycle count, LUT capture, map and done pulses.
  int cyc = 0, lut_n = 0, map_n = 0, map_bad = 0, done_n = 0;
  logic [CW-1:0] lut_cap [256];
  always @(posedge clk) begin
    cyc++;
    if (lut_we) begin lut_cap[lut_waddr] = lut_cdf; lut_n++; end
    if (map_valid) begin map_n++; if (map_pixel !== in_pixel) map_bad++; end
    if (done) done_n++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
`ifdef HE_CLIP_EN
    return (x > CL) ? CL : x;
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_phase(input logic [2:0] p, input string tag);
    int n = 0;
    while (phase !== p && n < 400) begin tick(); n++; end
    check(tag, 32'(phase), 32'(p));
  endtask

  task automatic start_frame(output int t0);
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] pix [16], input bit gaps);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_pixel = pix[i]; tick();
      if (gaps && i < 15) begin in_valid = 1'b0; in_pixel = 8'hff; tick(); end
    end
    in_valid = 1'b0;
  endtask

  task automatic map_pass(input string tag);
    int m0, b0;
    m0 = map_n; b0 = map_bad;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_pixel = 8'(i * 13 + 1); tick();
    end
    in_valid = 1'b0;
    check({tag, "_map_pulses"}, 32'(map_n - m0), 32'd16);
    check({tag, "_map_pixel"}, 32'(map_bad - b0), 32'd0);
  endtask

  initial begin
    logic [7:0] uni [16];
    logic [7:0] ramp [16];
    int t0, l0, d0, bad;
    for (int i = 0; i < 16; i++) begin uni[i] = 8'h80; ramp[i] = 8'(i); end

    // Reset with in_valid held high.
    reset = 1'b0; start = 1'b0; in_valid = 1'b1; in_pixel = 8'h55;
    repeat (3) tick();
    check("rst_phase", 32'(phase), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_hist_we", 32'(hist_we), 0);
    check("rst_lut_we", 32'(lut_we), 0);
    check("rst_map_valid", 32'(map_valid), 0);
    check("rst_addrs", 32'({hist_raddr, hist_waddr, lut_waddr, map_pixel}), 0);
    check("rst_data", 32'({hist_wdata, lut_cdf, lut_cdf_min}), 0);
    reset = 1'b1; tick();
    check("idle_in_ready", 32'(in_ready), 0);
    check("idle_phase", 32'(phase), 0);
    in_valid = 1'b0;

    // Uniform frame, no stalls: forwarding, LUT values and exact latency.
    d0 = done_n;
    start_frame(t0);
    check("clr_phase", 32'(phase), 1);
    check("clr_first_we", 32'({hist_we, hist_waddr, hist_wdata}), 32'({1'b1, 8'd0, 5'd0}));
    wait_phase(3'd2, "uni_accum");
    check("accum_in_ready", 32'(in_ready), 1);
    feed(uni, 1'b0);
    check("uni_drain", 32'(phase), 3);
    check("uni_drain_we", 32'({hist_we, hist_waddr}), 32'({1'b1, 8'h80}));
    l0 = lut_n;
    wait_phase(3'd5, "uni_map");
    check("uni_bin80", 32'(mem[8'h80]), 32'(sat(16)));
    check("uni_bin7f", 32'(mem[8'h7f]), 0);
    check("uni_lut_count", 32'(lut_n - l0), 256);
    check("uni_lut_7f", 32'(lut_cap[8'h7f]), 0);
    check("uni_lut_80", 32'(lut_cap[8'h80]), 32'(sat(16)));
    check("uni_lut_ff", 32'(lut_cap[8'hff]), 32'(sat(16)));
    check("uni_cdf_min", 32'(lut_cdf_min), 32'(sat(16)));
    map_pass("uni");
    check("uni_done", 32'(done), 1);
    check("uni_latency", 32'(cyc - t0), 547);
    tick();
    check("uni_back_idle", 32'(phase), 0);
    check("uni_done_once", 32'(done_n - d0), 1);

    // Mid-frame reset after 5 beats with a write in flight.
    start_frame(t0);
    wait_phase(3'd2, "rst_accum");
    for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_pixel = 8'd3; tick(); end
    in_valid = 1'b0;
    check("inflight_we", 32'(hist_we), 1);
    reset = 1'b0; tick();
    check("midrst_phase", 32'(phase), 0);
    check("midrst_we", 32'(hist_we), 0);
    check("midrst_busy", 32'(busy), 0);
    reset = 1'b1; tick();

    // Ramp with gaps; a start during CLEAR is ignored.
    start_frame(t0);
    start = 1'b1; tick(); start = 1'b0;
    check("start_ignored", 32'(phase), 1);
    wait_phase(3'd2, "ramp_accum");
    feed(ramp, 1'b1);
    check("ramp_drain", 32'(phase), 3);
    wait_phase(3'd5, "ramp_map");
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 5'd1) bad++;
    check("ramp_bins", 32'(bad), 0);
    check("ramp_bin16", 32'(mem[16]), 0);
    check("ramp_lut_0", 32'(lut_cap[0]), 1);
    check("ramp_lut_15", 32'(lut_cap[15]), 16);
    check("ramp_lut_ff", 32'(lut_cap[255]), 16);
    check("ramp_cdf_min", 32'(lut_cdf_min), 1);
    map_pass("ramp");
    check("ramp_done", 32'(done), 1);
    tick();
    check("ramp_back_idle", 32'(phase), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/he_sequencer.md
# he_sequencer

Phase controller for the histogram-equalization (HE) pipeline. It owns the histogram RAM and the LUT-build interface and sequences one frame through five phases: clear, accumulate, CDF/LUT build, map, done. It is the block that makes the two-pass pixel stream work:
- pass 1 feeds the histogram;
- pass 2 is remapped through the LUT.

It sits between the pixel source and the HE histogram/LUT datapath.

## Interface
Parameters:
- IMAGE_WIDTH, 660, pixels per line
- IMAGE_HEIGHT, 440, lines per frame
- CNT_W, 19, histogram bin/CDF width; must satisfy 2^CNT_W > IMAGE_WIDTH*IMAGE_HEIGHT
- CLIP_LIMIT, 2048, bin saturation value (used only with HE_CLIP_EN)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low; the block is reset while reset==0 at a rising edge
- start  in  1  one-cycle pulse; begins a frame when in IDLE
- in_valid  in  1  pixel beat valid
- in_pixel  in  8  pixel value
- in_ready  out  1  beat accepted when in_valid&&in_ready
- hist_raddr  out  8  histogram RAM read address (1R1W RAM, 1-cycle read latency)
- hist_rdata  in  CNT_W  histogram RAM read data
- hist_we  out  1  histogram write enable
- hist_waddr  out  8  histogram write address
- hist_wdata  out  CNT_W  histogram write data
- lut_we  out  1  LUT entry strobe
- lut_waddr  out  8  LUT entry index
- lut_cdf  out  CNT_W  cumulative count through bin lut_waddr
- lut_cdf_min  out  CNT_W  first non-zero CDF value of this frame
- map_valid  out  1  pass-2 pixel for the LUT read port
- map_pixel  out  8  LUT read address
- phase  out  3  current state encoding
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- N = IMAGE_WIDTH*IMAGE_HEIGHT. Beat = in_valid && in_ready.
- States and phase encoding: IDLE=0, CLEAR=1, ACCUM=2, DRAIN=3, CDF=4, MAP=5, DONE=6.

State behaviour:
- IDLE:
  - start -> CLEAR. start while busy is ignored.
- CLEAR:
  - hist_we=1, hist_waddr=0..255, hist_wdata=0; one bin per cycle.
  - -> ACCUM after bin 255 is written.
- ACCUM:
  - in_ready=1. Each beat drives hist_raddr=in_pixel.
  - The next cycle writes the old count +1 to that bin: hist_we=1, hist_waddr=the pixel.
  - Forwarding: if a beat's pixel equals the pixel of the write in flight, the forwarded value is used instead of hist_rdata. Back-to-back identical pixels count correctly.
  - Idle cycles (in_valid=0) do not disturb the pipeline.
  - After the N-th beat -> DRAIN.
- DRAIN:
  - One cycle; commits the last pending write. -> CDF.
- CDF:
  - hist_raddr steps 0..255 on consecutive cycles.
  - One cycle later: cdf += hist_rdata, then lut_we=1, lut_waddr=k, lut_cdf=running cdf.
  - lut_cdf_min latches the first non-zero cdf and is held until the next start.
  - 257 cycles total. -> MAP.
- MAP:
  - in_ready=1. map_valid=beat and map_pixel=in_pixel, both combinational.
  - After the N-th beat -> DONE.
- DONE:
  - done=1 for one cycle. -> IDLE.

Other rules:
- in_ready=0 in IDLE, CLEAR, DRAIN, CDF and DONE.
- Beat counter is CNT_W bits, cleared on entry to ACCUM and MAP.
- cdf accumulator is CNT_W bits. It cannot overflow by the parameter rule.
- Reset mid-frame: the next edge with reset==0 returns to IDLE, aborts any RAM write and clears all counters.

## Timing
- Reset values:
  - phase=0; busy, done, in_ready, hist_we, lut_we, map_valid = 0.
  - All addresses, hist_wdata, lut_cdf and lut_cdf_min = 0.
- start sampled at edge t: phase=1 and first clear write visible after t.
- Frame latency with no stalls, start to done: 1 + 256 + N + 1 + 257 + N cycles.
- Histogram update latency: write occurs exactly 1 cycle after its beat.
- Throughput: ACCUM and MAP sustain 1 pixel/cycle.

## Configuration
- HE_CLIP_EN defined:
  - ACCUM write data is min(count+1, CLIP_LIMIT); bins saturate at CLIP_LIMIT.
  - Forwarding path applies the same saturation.
- HE_CLIP_EN undefined:
  - Plain count+1, no comparator. CLIP_LIMIT is unused.

## Test plan
Benches use a 4x4 frame (N=16, CNT_W=5) unless stated.
- Reset/idle: hold reset=0 for 3 cycles, then release. All outputs 0, phase=0. in_valid=1 in IDLE gives in_ready=0.
- Uniform frame: 16 beats of pixel 0x80 back-to-back.
  - Bin 0x80 reads 16 (forwarding exercised).
  - In CDF, lut_cdf=0 for k<0x80 and 16 for k≥0x80; lut_cdf_min=16.
- Ramp with gaps: pixels 0..15 with in_valid toggling every cycle.
  - Bins 0..15 = 1 each; lut_cdf at k=15 is 16; lut_cdf_min=1.
- Full flow: MAP pass of 16 beats gives 16 map_valid pulses with map_pixel equal to in_pixel.
  - done pulses exactly once, at start+1+256+16+1+257+16 cycles when no stalls occur.
- Mid-frame reset: assert reset=0 during ACCUM after 5 beats.
  - Next cycle phase=0 and hist_we=0; a fresh start completes normally.
- Clip (HE_CLIP_EN, CLIP_LIMIT=4): 16 beats of pixel 7 -> bin 7 = 4; lut_cdf at 255 is 4.
